rv32_writeback: RTL and testbench
=================================

// Module: rv32_writeback
// PURPOSE
//  Final pipeline stage of the RV32 core: registers the memory-stage result, aligns and
//  sign/zero-extends load data, selects CSR read data, drives the register-file write port,
//  and emits the one-cycle instr_retired_out pulse consumed by the CSR block's instret counter.
// PARAMETERS
//  none (widths fixed by RV32: XLEN=32, 5-bit register index)
// PORTS
//  clk                 in   1   core clock, all state updates on posedge
//  reset               in   1   synchronous, active-high reset
//  valid_in            in   1   memory stage presents an instruction this cycle
//  stall_in            in   1   memory stage stalled; its outputs are not a new instruction
//  flush_in            in   1   kill the instruction currently presented (trap/redirect)
//  rd_in               in   5   destination register index
//  rd_write_in         in   1   instruction writes rd
//  mem_read_in         in   1   instruction is a load
//  mem_width_in        in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  mem_zero_extend_in  in   1   1 = LBU/LHU, 0 = LB/LH
//  addr_low_in         in   2   load address bits [1:0]
//  mem_read_value_in   in   32  raw 32-bit bus read word
//  csr_read_in         in   1   instruction is a CSR access; rd takes CSR old value
//  csr_read_value_in   in   32  CSR read value
//  result_in           in   32  ALU result
//  rd_out              out  5   register-file write index
//  rd_write_out        out  1   register-file write enable
//  rd_value_out        out  32  register-file write data
//  instr_retired_out   out  1   one-cycle pulse per retired instruction
// BEHAVIOUR
//  - Latency 1: inputs sampled at posedge N appear on outputs after posedge N.
//  - Capture condition C = valid_in & ~stall_in & ~flush_in.
//  - reset (sync, priority over all): rd_out=0, rd_write_out=0, rd_value_out=0,
//    instr_retired_out=0 (and trace outputs 0 when compiled in).
//  - C=1: rd_out<=rd_in; rd_value_out<=selected value; instr_retired_out<=1;
//    rd_write_out<=rd_write_in & (rd_in!=0). x0 writes suppressed; instruction still retires.
//  - C=0 (bubble, stall or flush): instr_retired_out<=0, rd_write_out<=0;
//    rd_out and rd_value_out hold previous values. A stall of K cycles yields no duplicate retire.
//  - flush_in has priority over stall_in and valid_in; reset mid-stall discards everything.
//  - Value select priority: mem_read_in -> load data; else csr_read_in -> csr_read_value_in;
//    else result_in. mem_read_in & csr_read_in together is illegal; load data wins.
//  - Load alignment: byte = mem_read_value_in[8*addr_low_in +: 8];
//    half = addr_low_in[1] ? [31:16] : [15:0], addr_low_in[0] ignored (misalignment trapped upstream);
//    word/reserved = full word, addr_low_in ignored.
//    Extension: mem_zero_extend_in ? zero-extend : replicate sign bit to 32.
//  - instr_retired_out asserts in the same cycle as the corresponding rd_write_out.
// CONFIGURATION
//  RV32_WB_TRACE_EN defined: adds ports pc_in (in, 32) and trace_pc_out (out, 32);
//    trace_pc_out<=pc_in when C=1, holds otherwise, 0 on reset; valid alongside instr_retired_out.
//  Undefined: those ports and registers do not exist; all other behaviour identical.
// TESTING
//  - reset=1 for 2 cycles with valid_in=1 -> all outputs 0, no retire pulse.
//  - ALU op rd=5, result 0x1234_5678 -> next cycle rd_out=5, rd_write_out=1,
//    rd_value_out=0x1234_5678, instr_retired_out=1 for exactly 1 cycle.
//  - LB addr_low=3, bus 0x80FF_0000 -> 0xFFFF_FF80; LBU -> 0x0000_0080; LH addr_low=2 -> 0xFFFF_80FF.
//  - rd_in=0, rd_write_in=1 -> rd_write_out=0, instr_retired_out=1.
//  - valid_in=1 with stall_in=1 for 3 cycles then released -> exactly one retire pulse;
//    flush_in=1 on the same instruction -> zero pulses and no write.
//  - CSR read rd=7, csr_read_value_in=0xDEAD_BEEF, result_in=0x1 -> rd_value_out=0xDEAD_BEEF;
//    with RV32_WB_TRACE_EN, pc_in=0x100 -> trace_pc_out=0x100 with the pulse.

Source files
------------

// File: rtl/rv32_writeback.sv
// RV32 writeback stage: registers the memory-stage result, aligns loads, drives the RF write port.
// Define RV32_WB_TRACE_EN to add pc_in / trace_pc_out retirement tracing.
module rv32_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic        mem_read_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [1:0]  addr_low_in,
  input  logic [31:0] mem_read_value_in,
  input  logic        csr_read_in,
  input  logic [31:0] csr_read_value_in,
  input  logic [31:0] result_in,
`ifdef RV32_WB_TRACE_EN
  input  logic [31:0] pc_in,
  output logic [31:0] trace_pc_out,
`endif
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        instr_retired_out
);

  logic        cap;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] sel_val;

  logic [4:0]  rd_q, rd_d;
  logic        rd_write_q, rd_write_d;
  logic [31:0] rd_value_q, rd_value_d;
  logic        retired_q, retired_d;

  assign cap = valid_in & ~stall_in & ~flush_in;

  always_comb begin
    byte_sel = mem_read_value_in[8*addr_low_in +: 8];
    half_sel = addr_low_in[1] ? mem_read_value_in[31:16]
                              : mem_read_value_in[15:0];
    load_val = mem_read_value_in;
    case (mem_width_in)
      2'b00: load_val = {{24{~mem_zero_extend_in & byte_sel[7]}},
                         byte_sel};
      2'b01: load_val = {{16{~mem_zero_extend_in & half_sel[15]}},
                         half_sel};
      default: load_val = mem_read_value_in;
    endcase
  end

  // Load beats CSR if both are flagged.
  always_comb begin
    sel_val = result_in;
    priority case (1'b1)
      mem_read_in: sel_val = load_val;
      csr_read_in: sel_val = csr_read_value_in;
      default:     sel_val = result_in;
    endcase
  end

  always_comb begin
    rd_d       = rd_q;
    rd_value_d = rd_value_q;
    rd_write_d = 1'b0;
    retired_d  = 1'b0;
    if (cap) begin
      rd_d       = rd_in;
      rd_value_d = sel_val;
      rd_write_d = rd_write_in & (rd_in != 5'd0);
      retired_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= 5'd0;
      rd_write_q <= 1'b0;
      rd_value_q <= 32'd0;
      retired_q  <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      rd_value_q <= rd_value_d;
      retired_q  <= retired_d;
    end
  end

  assign rd_out            = rd_q;
  assign rd_write_out      = rd_write_q;
  assign rd_value_out      = rd_value_q;
  assign instr_retired_out = retired_q;

`ifdef RV32_WB_TRACE_EN
  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (cap) pc_d = pc_in;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= 32'd0;
    else       pc_q <= pc_d;
  end

  assign trace_pc_out = pc_q;
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// Bench for rv32_writeback: directed spec cases plus randomized traffic
// checked cycle-by-cycle against a queue-based reference model.
module tb_rv32_writeback;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        rd_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic [1:0]  mem_width_in = '0;
  logic        mem_zero_extend_in = 1'b0;
  logic [1:0]  addr_low_in = '0;
  logic [31:0] mem_read_value_in = '0;
  logic        csr_read_in = 1'b0;
  logic [31:0] csr_read_value_in = '0;
  logic [31:0] result_in = '0;
  logic [31:0] pc_in = '0;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        instr_retired_out;
`ifdef RV32_WB_TRACE_EN
  logic [31:0] trace_pc_out;
`endif

  rv32_writeback dut (
    .clk                (clk),
    .reset              (reset),
    .valid_in           (valid_in),
    .stall_in           (stall_in),
    .flush_in           (flush_in),
    .rd_in              (rd_in),
    .rd_write_in        (rd_write_in),
    .mem_read_in        (mem_read_in),
    .mem_width_in       (mem_width_in),
    .mem_zero_extend_in (mem_zero_extend_in),
    .addr_low_in        (addr_low_in),
    .mem_read_value_in  (mem_read_value_in),
    .csr_read_in        (csr_read_in),
    .csr_read_value_in  (csr_read_value_in),
    .result_in          (result_in),
`ifdef RV32_WB_TRACE_EN
    .pc_in              (pc_in),
    .trace_pc_out       (trace_pc_out),
`endif
    .rd_out             (rd_out),
    .rd_write_out       (rd_write_out),
    .rd_value_out       (rd_value_out),
    .instr_retired_out  (instr_retired_out)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] val;
    logic        ret;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Load extraction by shifting, masking and two's-complement wrap.
  function automatic logic [31:0] ref_load(logic [1:0] w, logic ze,
                                           logic [1:0] al,
                                           logic [31:0] word);
    longint unsigned v;
    int unsigned bits;
    case (w)
      2'd0: begin v = longint'(word >> (8 * al)) % 256; bits = 8; end
      2'd1: begin
        v = longint'(word >> ((al >= 2) ? 16 : 0)) % 65536;
        bits = 16;
      end
      default: return word;
    endcase
    if (!ze && v >= (64'd1 << (bits - 1)))
      v = v + (64'h1_0000_0000 - (64'd1 << bits));
    return v[31:0];
  endfunction

  logic [4:0]  m_rd  = '0;
  logic [31:0] m_val = '0;
  logic [31:0] m_pc  = '0;

  // Reference model: one expected output state per clock edge.
  always @(posedge clk) begin : model
    exp_t e;
    if (reset) begin
      m_rd = '0; m_val = '0; m_pc = '0;
      e.we = 1'b0; e.ret = 1'b0;
    end else if (valid_in && !stall_in && !flush_in) begin
      m_rd  = rd_in;
      m_val = mem_read_in ? ref_load(mem_width_in, mem_zero_extend_in,
                                     addr_low_in, mem_read_value_in)
            : csr_read_in ? csr_read_value_in : result_in;
      m_pc  = pc_in;
      e.we  = rd_write_in && (rd_in != 5'd0);
      e.ret = 1'b1;
    end else begin
      e.we = 1'b0; e.ret = 1'b0;
    end
    e.rd = m_rd; e.val = m_val; e.pc = m_pc;
    q.push_back(e);
  end

  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        chk("sb_rd_write_out", {31'd0, rd_write_out}, {31'd0, e.we});
        chk("sb_rd_value_out", rd_value_out, e.val);
        chk("sb_retired", {31'd0, instr_retired_out}, {31'd0, e.ret});
`ifdef RV32_WB_TRACE_EN
        chk("sb_trace_pc", trace_pc_out, e.pc);
`endif
      end
      if (instr_retired_out === 1'b1) pulses++;
    end
  end

  task automatic clr();
    valid_in = 0; stall_in = 0; flush_in = 0; rd_in = 0;
    rd_write_in = 0; mem_read_in = 0; mem_width_in = 0;
    mem_zero_extend_in = 0; addr_low_in = 0; csr_read_in = 0;
  endtask

  task automatic load(logic [1:0] w, logic ze, logic [1:0] al,
                      logic [31:0] word);
    clr();
    valid_in = 1; rd_in = 5'd3; rd_write_in = 1; mem_read_in = 1;
    mem_width_in = w; mem_zero_extend_in = ze; addr_low_in = al;
    mem_read_value_in = word; result_in = 32'h5555_5555;
  endtask

  int p0;

  initial begin : driver
    // Reset held two cycles with an instruction presented.
    valid_in = 1; rd_in = 5'd5; rd_write_in = 1; result_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("reset_c1_retired", {31'd0, instr_retired_out}, 32'd0);
    chk("reset_c1_we", {31'd0, rd_write_out}, 32'd0);
    @(posedge clk); #1;
    chk("reset_c2_retired", {31'd0, instr_retired_out}, 32'd0);
    chk("reset_c2_value", rd_value_out, 32'd0);
    chk("reset_c2_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk); reset = 0; clr();

    @(negedge clk);
    valid_in = 1; rd_in = 5'd5; rd_write_in = 1; result_in = 32'h1234_5678;
    @(posedge clk); #1;
    chk("alu_rd", {27'd0, rd_out}, 32'd5);
    chk("alu_we", {31'd0, rd_write_out}, 32'd1);
    chk("alu_value", rd_value_out, 32'h1234_5678);
    chk("alu_retired", {31'd0, instr_retired_out}, 32'd1);
    @(negedge clk); clr();
    @(posedge clk); #1;
    chk("alu_pulse_one_cycle", {31'd0, instr_retired_out}, 32'd0);
    chk("alu_value_hold", rd_value_out, 32'h1234_5678);

    @(negedge clk); load(2'd0, 1'b0, 2'd3, 32'h80FF_0000);
    @(posedge clk); #1; chk("lb_al3", rd_value_out, 32'hFFFF_FF80);
    @(negedge clk); load(2'd0, 1'b1, 2'd3, 32'h80FF_0000);
    @(posedge clk); #1; chk("lbu_al3", rd_value_out, 32'h0000_0080);
    @(negedge clk); load(2'd1, 1'b0, 2'd2, 32'h80FF_0000);
    @(posedge clk); #1; chk("lh_al2", rd_value_out, 32'hFFFF_80FF);
    @(negedge clk); load(2'd1, 1'b1, 2'd1, 32'h1234_F00D);
    @(posedge clk); #1; chk("lhu_al1_ignored", rd_value_out, 32'h0000_F00D);
    @(negedge clk); load(2'd3, 1'b0, 2'd2, 32'h8765_4321);
    @(posedge clk); #1; chk("lw_reserved", rd_value_out, 32'h8765_4321);

    @(negedge clk); clr();
    valid_in = 1; rd_in = 5'd0; rd_write_in = 1; result_in = 32'h77;
    @(posedge clk); #1;
    chk("x0_we", {31'd0, rd_write_out}, 32'd0);
    chk("x0_retired", {31'd0, instr_retired_out}, 32'd1);

    // Three stall cycles, then release: one retirement only.
    @(negedge clk); clr(); #1; p0 = pulses;
    valid_in = 1; stall_in = 1; rd_in = 5'd9; rd_write_in = 1;
    result_in = 32'hABCD_0009;
    repeat (3) @(negedge clk);
    stall_in = 0;
    @(negedge clk); clr();
    repeat (2) @(negedge clk);
    #1 chk("stall_pulses", pulses - p0, 32'd1);

    // Flushed while stalled: nothing retires.
    @(negedge clk); #1; p0 = pulses;
    valid_in = 1; stall_in = 1; flush_in = 1; rd_in = 5'd10; rd_write_in = 1;
    @(negedge clk); stall_in = 0;
    @(negedge clk); clr();
    repeat (2) @(negedge clk);
    #1 chk("flush_pulses", pulses - p0, 32'd0);
    chk("flush_value_hold", rd_value_out, 32'hABCD_0009);

    @(negedge clk); clr();
    valid_in = 1; rd_in = 5'd7; rd_write_in = 1; csr_read_in = 1;
    csr_read_value_in = 32'hDEAD_BEEF; result_in = 32'h1; pc_in = 32'h100;
    @(posedge clk); #1;
    chk("csr_value", rd_value_out, 32'hDEAD_BEEF);
    chk("csr_rd", {27'd0, rd_out}, 32'd7);
`ifdef RV32_WB_TRACE_EN
    chk("csr_trace_pc", trace_pc_out, 32'h100);
`endif

    // Reset in the middle of a stall drops the held instruction.
    @(negedge clk); clr(); #1; p0 = pulses;
    valid_in = 1; stall_in = 1; rd_in = 5'd11; rd_write_in = 1;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; clr();
    repeat (2) @(negedge clk);
    #1 chk("reset_mid_stall_pulses", pulses - p0, 32'd0);
    chk("reset_mid_stall_value", rd_value_out, 32'd0);

    repeat (3000) begin
      @(negedge clk);
      reset              = ($urandom_range(63) == 0);
      valid_in           = ($urandom_range(3) != 0);
      stall_in           = ($urandom_range(4) == 0);
      flush_in           = ($urandom_range(7) == 0);
      rd_in              = 5'($urandom);
      rd_write_in        = ($urandom_range(5) != 0);
      mem_read_in        = ($urandom_range(2) == 0);
      csr_read_in        = ($urandom_range(3) == 0);
      mem_width_in       = 2'($urandom);
      mem_zero_extend_in = 1'($urandom);
      addr_low_in        = 2'($urandom);
      mem_read_value_in  = $urandom;
      csr_read_value_in  = $urandom;
      result_in          = $urandom;
      pc_in              = $urandom;
    end

    @(negedge clk); reset = 0; clr();
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
